// File: rtl/io_seg_pkg.sv
// Shared types and constants for the io_seg_display 7-segment output peripheral.
package io_seg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NUM_DIGITS = 8;
  localparam int BCD_DIGITS = 10;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

endpackage

// File: rtl/seg7_decode.sv
// Hex nibble to active-low 7-segment pattern (bit0 = a ... bit6 = g).
module seg7_decode (
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = 7'h7F;
    unique case (nibble)
      4'h0: seg_n = 7'h40;
      4'h1: seg_n = 7'h79;
      4'h2: seg_n = 7'h24;
      4'h3: seg_n = 7'h30;
      4'h4: seg_n = 7'h19;
      4'h5: seg_n = 7'h12;
      4'h6: seg_n = 7'h02;
      4'h7: seg_n = 7'h78;
      4'h8: seg_n = 7'h00;
      4'h9: seg_n = 7'h10;
      4'hA: seg_n = 7'h08;
      4'hB: seg_n = 7'h03;
      4'hC: seg_n = 7'h46;
      4'hD: seg_n = 7'h21;
      4'hE: seg_n = 7'h06;
      4'hF: seg_n = 7'h0E;
    endcase
  end

endmodule

// File: rtl/io_seg_display.sv
// 8-digit multiplexed 7-segment display of a 32-bit CPU output port, hex or decimal.
// Optional leading-zero blanking in decimal mode: define IO_SEG_BLANK_EN.
module io_seg_display
  import io_seg_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] disp_value,
  input  logic        disp_hex,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic [7:0]  an_n,
  output logic        busy,
  output logic        ovf
);

  localparam int RW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [RW-1:0] REF_MAX = RW'(REFRESH_DIV - 1);

  state_t        state, next_state;
  logic [31:0]   last_value, bin, disp_reg;
  logic          last_hex;
  logic [39:0]   bcd;
  logic [4:0]    iter;
  logic          start;

  logic [RW-1:0] refresh;
  logic [IW-1:0] idx;
  logic [6:0]    seg_raw, seg_sel;
  logic          lead_zero;

  function automatic logic [39:0] dabble_adjust(input logic [39:0] v);
    logic [39:0] r;
    r = v;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (v[4*i +: 4] >= 4'd5) r[4*i +: 4] = v[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  assign start = (state == IDLE) && ({disp_value, disp_hex} != {last_value, last_hex});

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: if (start) next_state = disp_hex ? DONE : CONV;
      CONV: if (iter == 5'd31) next_state = DONE;
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  // Double-dabble datapath: one add-3/shift iteration per CONV cycle
  always_ff @(posedge clock) begin
    if (start) begin
      bin  <= disp_value;
      bcd  <= '0;
      iter <= '0;
    end else if (state == CONV) begin
      {bcd, bin} <= {dabble_adjust(bcd), bin} << 1;
      iter       <= iter + 5'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last_value <= '0;
      last_hex   <= 1'b0;
      disp_reg   <= '0;
      ovf        <= 1'b0;
    end else begin
      if (start) begin
        last_value <= disp_value;
        last_hex   <= disp_hex;
      end
      if (state == DONE) begin
        if (last_hex) begin
          disp_reg <= last_value;
          ovf      <= 1'b0;
        end else begin
          disp_reg <= bcd[31:0];
          ovf      <= |bcd[39:32];
        end
      end
    end
  end

  seg7_decode u_decode (
    .nibble (disp_reg[{idx, 2'b00} +: 4]),
    .seg_n  (seg_raw)
  );

`ifdef IO_SEG_BLANK_EN
  // A digit is a leading zero when it and every digit above it are zero
  assign lead_zero = (idx != '0) && !last_hex && ((disp_reg >> {idx, 2'b00}) == 32'd0);
`else
  assign lead_zero = 1'b0;
`endif

  always_comb begin
    seg_sel = seg_raw;
    if (ovf)            seg_sel = SEG_DASH;
    else if (lead_zero) seg_sel = SEG_BLANK;
  end

  // Scanner: free-running, outputs registered one cycle behind idx/disp_reg
  always_ff @(posedge clock) begin
    if (reset) begin
      refresh <= '0;
      idx     <= '0;
      seg_n   <= SEG_BLANK;
      dp_n    <= 1'b1;
      an_n    <= 8'hFF;
    end else begin
      if (refresh == REF_MAX) begin
        refresh <= '0;
        idx     <= idx + 1'b1;
      end else begin
        refresh <= refresh + 1'b1;
      end
      an_n  <= ~(8'b1 << idx);
      seg_n <= seg_sel;
      dp_n  <= ~(disp_hex && (idx == 3'd4));
    end
  end

endmodule
